arrow_pool: RTL and testbench

ARROW_POOL -- requirements
Module: arrow_pool

---
 rtl/arrow_pkg.sv | 66 ++++++
 rtl/arrow_slot.sv | 86 ++++++++
 rtl/arrow_pool.sv | 120 ++++++++++++
 tb/tb_arrow_pool.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arrow_pkg.sv
// Shared arrow definitions: directions, playfield centre, spawn points,
// shield windows and sprite colour.
package arrow_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'b00,
        DIR_UP    = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    localparam logic [10:0] CENTRE_X     = 11'd512;
    localparam logic [9:0]  CENTRE_Y     = 10'd384;
    localparam logic [11:0] ARROW_COLOUR = 12'hF00;

    localparam logic [10:0] SPAWN_X_MID   = 11'd512;
    localparam logic [10:0] SPAWN_X_LEFT  = 11'd0;
    localparam logic [10:0] SPAWN_X_RIGHT = 11'd1024;
    localparam logic [9:0]  SPAWN_Y_TOP   = 10'd0;
    localparam logic [9:0]  SPAWN_Y_BOT   = 10'd720;
    localparam logic [9:0]  SPAWN_Y_MID   = 10'd384;

    localparam logic [9:0]  WIN_DOWN_LO  = 10'd288;
    localparam logic [9:0]  WIN_DOWN_HI  = 10'd320;
    localparam logic [9:0]  WIN_UP_LO    = 10'd440;
    localparam logic [9:0]  WIN_UP_HI    = 10'd472;
    localparam logic [10:0] WIN_RIGHT_LO = 11'd448;
    localparam logic [10:0] WIN_RIGHT_HI = 11'd480;
    localparam logic [10:0] WIN_LEFT_LO  = 11'd536;
    localparam logic [10:0] WIN_LEFT_HI  = 11'd568;

    function automatic logic [10:0] spawn_x(input dir_t d);
        case (d)
            DIR_RIGHT: return SPAWN_X_LEFT;
            DIR_LEFT:  return SPAWN_X_RIGHT;
            default:   return SPAWN_X_MID;
        endcase
    endfunction

    function automatic logic [9:0] spawn_y(input dir_t d);
        case (d)
            DIR_DOWN: return SPAWN_Y_TOP;
            DIR_UP:   return SPAWN_Y_BOT;
            default:  return SPAWN_Y_MID;
        endcase
    endfunction

    function automatic logic in_window(input dir_t d, input logic [10:0] x, input logic [9:0] y);
        case (d)
            DIR_DOWN:  return (y >= WIN_DOWN_LO) && (y <= WIN_DOWN_HI);
            DIR_UP:    return (y >= WIN_UP_LO) && (y <= WIN_UP_HI);
            DIR_RIGHT: return (x >= WIN_RIGHT_LO) && (x <= WIN_RIGHT_HI);
            default:   return (x >= WIN_LEFT_LO) && (x <= WIN_LEFT_HI);
        endcase
    endfunction

    function automatic logic at_centre(input dir_t d, input logic [10:0] x, input logic [9:0] y);
        case (d)
            DIR_DOWN:  return y >= CENTRE_Y;
            DIR_UP:    return y <= CENTRE_Y;
            DIR_RIGHT: return x >= CENTRE_X;
            default:   return x <= CENTRE_X;
        endcase
    endfunction

endpackage

// File: rtl/arrow_slot.sv
// One arrow slot: spawn load, per-frame movement, shield/centre resolution
// and sprite hit-test against the current pixel.
//
// state  | meaning
// S_IDLE | slot free, eligible for the next spawn
// S_FLY  | arrow live; moves one step per frame tick until blocked or hit
module arrow_slot
    import arrow_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [1:0]  dir_in,
    input  logic [2:0]  speed_in,
    input  logic        tick,
    input  logic [1:0]  rotate_in,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic        fly,
    output logic        hit,
    output logic        blk,
    output logic        on_pixel
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FLY  = 1'b1;

    logic [0:0]  state;
    logic [10:0] x;
    logic [9:0]  y;
    dir_t        dir;
    logic [4:0]  step;

    assign fly = (state == S_FLY);

    // Shield takes priority over the centre test on the same tick.
    assign blk = fly && tick && (dir_t'(rotate_in) == dir) && in_window(dir, x, y);
    assign hit = fly && tick && !blk && at_centre(dir, x, y);

    assign on_pixel = fly
        && ({1'b0, hcount} >= {1'b0, x})
        && ({1'b0, hcount} <= ({1'b0, x} + 12'(WIDTH)))
        && ({1'b0, vcount} >= {1'b0, y})
        && ({1'b0, vcount} <= ({1'b0, y} + 11'(HEIGHT)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            x     <= '0;
            y     <= '0;
            dir   <= DIR_DOWN;
            step  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        state <= S_FLY;
                        x     <= spawn_x(dir_t'(dir_in));
                        y     <= spawn_y(dir_t'(dir_in));
                        dir   <= dir_t'(dir_in);
                        step  <= {({1'b0, speed_in} + 4'd1), 1'b0};
                    end
                end
                S_FLY: begin
                    if (tick) begin
                        if (blk || hit) begin
                            state <= S_IDLE;
                        end else begin
                            case (dir)
                                DIR_DOWN:  y <= y + {5'd0, step};
                                DIR_UP:    y <= y - {5'd0, step};
                                DIR_RIGHT: x <= x + {6'd0, step};
                                default:   x <= x - {6'd0, step};
                            endcase
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/arrow_pool.sv
// Pool of N_ARROWS arrow slots with spawn allocation, event pulses and sprite output.
// Define ARROW_POOL_SCORE_EN to enable the saturating blocked_count score.
module arrow_pool
    import arrow_pkg::*;
#(
    parameter int N_ARROWS = 4,
    parameter int WIDTH    = 8,
    parameter int HEIGHT   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [10:0]         hcount_in,
    input  logic [9:0]          vcount_in,
    input  logic                spawn_valid,
    output logic                spawn_ready,
    input  logic [1:0]          spawn_dir,
    input  logic [2:0]          spawn_speed,
    input  logic [1:0]          rotate_in,
    output logic [11:0]         pixel_out,
    output logic                valid_out,
    output logic                hit_player,
    output logic                blocked,
    output logic [N_ARROWS-1:0] hit_mask,
    output logic [3:0]          active_count,
    output logic [15:0]         blocked_count
);

    logic                tick;
    logic [N_ARROWS-1:0] fly;
    logic [N_ARROWS-1:0] load;
    logic [N_ARROWS-1:0] hit_evt;
    logic [N_ARROWS-1:0] blk_evt;
    logic [N_ARROWS-1:0] on_pix;
    logic                found;

    assign tick        = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign spawn_ready = ~&fly;

    // Allocation looks at current state only, so a slot ending on this tick is not eligible yet.
    always_comb begin
        load  = '0;
        found = 1'b0;
        for (int i = 0; i < N_ARROWS; i++) begin
            if (!fly[i] && !found) begin
                load[i] = spawn_valid;
                found   = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_ARROWS; g++) begin : g_slot
        arrow_slot #(
            .WIDTH  (WIDTH),
            .HEIGHT (HEIGHT)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[g]),
            .dir_in    (spawn_dir),
            .speed_in  (spawn_speed),
            .tick      (tick),
            .rotate_in (rotate_in),
            .hcount    (hcount_in),
            .vcount    (vcount_in),
            .fly       (fly[g]),
            .hit       (hit_evt[g]),
            .blk       (blk_evt[g]),
            .on_pixel  (on_pix[g])
        );
    end

    always_comb begin
        active_count = '0;
        for (int i = 0; i < N_ARROWS; i++) begin
            active_count = active_count + {3'b000, fly[i]};
        end
    end

    assign valid_out = |on_pix;
    assign pixel_out = valid_out ? ARROW_COLOUR : 12'h000;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_player <= 1'b0;
            blocked    <= 1'b0;
            hit_mask   <= '0;
        end else begin
            hit_player <= |hit_evt;
            blocked    <= |blk_evt;
            hit_mask   <= hit_evt;
        end
    end

`ifdef ARROW_POOL_SCORE_EN
    logic [3:0]  n_blk;
    logic [16:0] score_sum;
    logic [15:0] score;

    always_comb begin
        n_blk = '0;
        for (int i = 0; i < N_ARROWS; i++) begin
            n_blk = n_blk + {3'b000, blk_evt[i]};
        end
        score_sum = {1'b0, score} + {13'd0, n_blk};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score <= '0;
        end else begin
            score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
    end

    assign blocked_count = score;
`else
    assign blocked_count = 16'h0000;
`endif

endmodule

// File: tb/tb_arrow_pool.sv
// Self-checking bench for arrow_pool: directed scenarios plus randomized traffic
// compared every cycle against a slot-list model of the game rules.
module tb_arrow_pool;

    localparam int N = 4;
    localparam int W = 8;
    localparam int H = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount_in = 11'd100;
    logic [9:0]  vcount_in = 10'd100;
    logic        spawn_valid = 1'b0;
    logic        spawn_ready;
    logic [1:0]  spawn_dir = 2'd0;
    logic [2:0]  spawn_speed = 3'd0;
    logic [1:0]  rotate_in = 2'd0;
    logic [11:0] pixel_out;
    logic        valid_out;
    logic        hit_player;
    logic        blocked;
    logic [N-1:0] hit_mask;
    logic [3:0]  active_count;
    logic [15:0] blocked_count;

    arrow_pool #(.N_ARROWS(N), .WIDTH(W), .HEIGHT(H)) dut (
        .clk           (clk),
        .rst           (rst),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .spawn_valid   (spawn_valid),
        .spawn_ready   (spawn_ready),
        .spawn_dir     (spawn_dir),
        .spawn_speed   (spawn_speed),
        .rotate_in     (rotate_in),
        .pixel_out     (pixel_out),
        .valid_out     (valid_out),
        .hit_player    (hit_player),
        .blocked       (blocked),
        .hit_mask      (hit_mask),
        .active_count  (active_count),
        .blocked_count (blocked_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a list of live arrows with plain integer positions.
    bit m_fly  [N];
    int m_x    [N];
    int m_y    [N];
    int m_dir  [N];
    int m_step [N];
    int e_mask = 0;
    int e_hp   = 0;
    int e_bl   = 0;
    int e_bcnt = 0;

    int start_x [4] = '{512, 512, 0, 1024};
    int start_y [4] = '{0, 720, 384, 384};
    int win_lo  [4] = '{288, 440, 448, 536};

    task automatic check1(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int cnt;
        int vis;
        bit idle_any;
        cnt = 0;
        vis = 0;
        idle_any = 0;
        for (int i = 0; i < N; i++) begin
            if (m_fly[i]) begin
                cnt++;
                if (int'(hcount_in) >= m_x[i] && int'(hcount_in) <= m_x[i] + W &&
                    int'(vcount_in) >= m_y[i] && int'(vcount_in) <= m_y[i] + H)
                    vis = 1;
            end else begin
                idle_any = 1;
            end
        end
        check1("valid_out", valid_out, vis);
        check1("pixel_out", pixel_out, vis ? 12'hF00 : 0);
        check1("spawn_ready", spawn_ready, idle_any);
        check1("active_count", active_count, cnt);
        check1("hit_player", hit_player, e_hp);
        check1("blocked", blocked, e_bl);
        check1("hit_mask", hit_mask, e_mask);
        check1("blocked_count", blocked_count, e_bcnt);
    endtask

    task automatic model_edge();
        int tgt;
        int hits;
        int nblk;
        int coord;
        bit centre;
        if (rst) begin
            for (int i = 0; i < N; i++) m_fly[i] = 0;
            e_mask = 0; e_hp = 0; e_bl = 0; e_bcnt = 0;
        end else begin
            tgt = -1;
            if (spawn_valid)
                for (int i = 0; i < N; i++)
                    if (!m_fly[i] && tgt < 0) tgt = i;
            hits = 0;
            nblk = 0;
            if (hcount_in == 0 && vcount_in == 0) begin
                for (int i = 0; i < N; i++) begin
                    if (m_fly[i]) begin
                        coord = (m_dir[i] < 2) ? m_y[i] : m_x[i];
                        case (m_dir[i])
                            0: centre = m_y[i] >= 384;
                            1: centre = m_y[i] <= 384;
                            2: centre = m_x[i] >= 512;
                            default: centre = m_x[i] <= 512;
                        endcase
                        if (int'(rotate_in) == m_dir[i] && coord >= win_lo[m_dir[i]] &&
                            coord <= win_lo[m_dir[i]] + 32) begin
                            m_fly[i] = 0;
                            nblk++;
                        end else if (centre) begin
                            m_fly[i] = 0;
                            hits |= (1 << i);
                        end else begin
                            case (m_dir[i])
                                0: m_y[i] += m_step[i];
                                1: m_y[i] -= m_step[i];
                                2: m_x[i] += m_step[i];
                                default: m_x[i] -= m_step[i];
                            endcase
                        end
                    end
                end
            end
            if (tgt >= 0) begin
                m_fly[tgt]  = 1;
                m_dir[tgt]  = int'(spawn_dir);
                m_step[tgt] = 2 * (int'(spawn_speed) + 1);
                m_x[tgt]    = start_x[spawn_dir];
                m_y[tgt]    = start_y[spawn_dir];
            end
            e_mask = hits;
            e_hp   = (hits != 0) ? 1 : 0;
            e_bl   = (nblk != 0) ? 1 : 0;
`ifdef ARROW_POOL_SCORE_EN
            e_bcnt = (e_bcnt + nblk > 65535) ? 65535 : e_bcnt + nblk;
`else
            e_bcnt = 0;
`endif
        end
    endtask

    // Drive one cycle's inputs, compare outputs against the model, then advance the model.
    task automatic step_cycle(input bit r, input bit sv, input int d, input int sp,
                              input int rot, input int h, input int v);
        @(negedge clk);
        rst         = r;
        spawn_valid = sv;
        spawn_dir   = 2'(d);
        spawn_speed = 3'(sp);
        rotate_in   = 2'(rot);
        hcount_in   = 11'(h);
        vcount_in   = 10'(v);
        #1;
        check_all();
        model_edge();
    endtask

    task automatic do_reset();
        step_cycle(1, 0, 0, 0, 0, 100, 100);
        step_cycle(1, 0, 0, 0, 0, 100, 100);
        step_cycle(0, 0, 0, 0, 0, 100, 100);
    endtask

    task automatic fly_until_event(input bit sv, input int d, input int sp, input int rot,
                                   output int moves, output bit seen, output bit rdy_tick);
        seen = 0;
        moves = 0;
        rdy_tick = 0;
        for (int n = 0; n < 400 && !seen; n++) begin
            step_cycle(0, sv, d, sp, rot, 0, 0);
            rdy_tick = spawn_ready;
            step_cycle(0, sv, d, sp, rot, 100, 100);
            if (hit_player || blocked) seen = 1;
            else moves++;
        end
    endtask

    int moves;
    bit seen;
    bit rdy_tick;
    int cur_rot;
    int mode;
    int k;
    int hh;
    int vv;

    initial begin
        for (int i = 0; i < N; i++) m_fly[i] = 0;

        // Reset state
        do_reset();
        check1("rst_ready", spawn_ready, 1);
        check1("rst_active", active_count, 0);
        check1("rst_hit", hit_player, 0);
        check1("rst_bcnt", blocked_count, 0);

        // Down arrow, step 4, shield down: blocked after 72 moves (y=288)
        step_cycle(0, 1, 0, 1, 0, 100, 100);
        fly_until_event(0, 0, 0, 0, moves, seen, rdy_tick);
        check1("blk_seen", seen, 1);
        check1("blk_moves", moves, 72);
        check1("blk_pulse", blocked, 1);
        check1("blk_no_hit", hit_player, 0);
        check1("blk_active", active_count, 0);
`ifdef ARROW_POOL_SCORE_EN
        check1("blk_count", blocked_count, 1);
`else
        check1("blk_count", blocked_count, 0);
`endif
        step_cycle(0, 0, 0, 0, 0, 100, 100);
        check1("blk_single", blocked, 0);

        // Right arrow, step 8, wrong shield: hit after 64 moves (x=512)
        do_reset();
        step_cycle(0, 1, 2, 3, 0, 100, 100);
        fly_until_event(0, 0, 0, 0, moves, seen, rdy_tick);
        check1("hit_seen", seen, 1);
        check1("hit_moves", moves, 64);
        check1("hit_pulse", hit_player, 1);
        check1("hit_mask1", hit_mask, 1);
        check1("hit_no_blk", blocked, 0);
        check1("hit_active", active_count, 0);

        // Full pool: held fifth spawn waits for a free slot
        do_reset();
        step_cycle(0, 1, 0, 7, 3, 100, 100);
        for (int i = 0; i < 3; i++) step_cycle(0, 1, 1, 0, 3, 100, 100);
        step_cycle(0, 1, 2, 0, 3, 100, 100);
        check1("full_ready", spawn_ready, 0);
        check1("full_active", active_count, 4);
        fly_until_event(1, 2, 0, 3, moves, seen, rdy_tick);
        check1("full_seen", seen, 1);
        check1("full_moves", moves, 24);
        check1("full_mask", hit_mask, 1);
        check1("full_tick_ready", rdy_tick, 0);
        check1("full_freed_ready", spawn_ready, 1);
        check1("full_freed_active", active_count, 3);
        step_cycle(0, 0, 0, 0, 3, 100, 100);
        check1("full_refill", active_count, 4);

        // Two arrows reach centre on the same tick
        do_reset();
        step_cycle(0, 1, 2, 7, 0, 100, 100);
        step_cycle(0, 1, 3, 7, 0, 100, 100);
        fly_until_event(0, 0, 0, 0, moves, seen, rdy_tick);
        check1("dual_moves", moves, 32);
        check1("dual_hit", hit_player, 1);
        check1("dual_mask", hit_mask, 3);
        step_cycle(0, 0, 0, 0, 0, 100, 100);
        check1("dual_single", hit_player, 0);

        // Sprite bounds, then reset mid-flight with three arrows live
        do_reset();
        step_cycle(0, 1, 0, 0, 0, 100, 100);
        step_cycle(0, 1, 1, 0, 0, 100, 100);
        step_cycle(0, 1, 2, 0, 0, 100, 100);
        step_cycle(0, 0, 0, 0, 0, 516, 10);
        check1("spr_in", valid_out, 1);
        check1("spr_colour", pixel_out, 12'hF00);
        check1("spr_active", active_count, 3);
        step_cycle(0, 0, 0, 0, 0, 521, 10);
        check1("spr_right_edge", valid_out, 0);
        step_cycle(0, 0, 0, 0, 0, 520, 32);
        check1("spr_corner", valid_out, 1);
        step_cycle(1, 0, 0, 0, 0, 516, 10);
        step_cycle(0, 0, 0, 0, 0, 516, 10);
        check1("mid_rst_active", active_count, 0);
        check1("mid_rst_valid", valid_out, 0);
        check1("mid_rst_pixel", pixel_out, 0);
        check1("mid_rst_ready", spawn_ready, 1);

        // Randomized traffic
        cur_rot = 0;
        for (int c = 0; c < 15000; c++) begin
            if ($urandom_range(0, 7) == 0) cur_rot = $urandom_range(0, 3);
            mode = $urandom_range(0, 3);
            if (mode == 0) begin
                hh = 0; vv = 0;
            end else if (mode == 1) begin
                hh = $urandom_range(0, 1100); vv = $urandom_range(0, 760);
            end else begin
                k = $urandom_range(0, N - 1);
                hh = m_x[k] + $urandom_range(0, W + 2) - 1;
                vv = m_y[k] + $urandom_range(0, H + 2) - 1;
                if (hh < 0) hh = 0;
                if (vv < 0) vv = 0;
                if (hh > 2047) hh = 2047;
                if (vv > 1023) vv = 1023;
            end
            step_cycle($urandom_range(0, 999) == 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 3), $urandom_range(0, 7), cur_rot, hh, vv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
